// File: rtl/cmd_completer.sv
// rtl/cmd_completer.sv - command tag allocator, engine issue register and completion responder
module cmd_completer #(
    parameter int CLUSTER_ID_WIDTH = 16,
    parameter int CORE_ID_WIDTH    = 16,
    parameter int LOCAL_ID_WIDTH   = 2,
    parameter int PAYLOAD_WIDTH    = 64,
    parameter int NUM_INFLIGHT     = 8,
    localparam int TAG_W           = $clog2(NUM_INFLIGHT),
    localparam int CNT_W           = $clog2(NUM_INFLIGHT + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [CLUSTER_ID_WIDTH-1:0] cmd_cluster_id_i,
    input  logic [CORE_ID_WIDTH-1:0]    cmd_core_id_i,
    input  logic [LOCAL_ID_WIDTH-1:0]   cmd_local_id_i,
    input  logic [PAYLOAD_WIDTH-1:0]    cmd_payload_i,
    output logic                        eng_valid_o,
    input  logic                        eng_ready_i,
    output logic [TAG_W-1:0]            eng_tag_o,
    output logic [PAYLOAD_WIDTH-1:0]    eng_payload_o,
    input  logic                        eng_done_valid_i,
    input  logic [TAG_W-1:0]            eng_done_tag_i,
    output logic                        cmd_resp_valid_o,
    output logic [CLUSTER_ID_WIDTH-1:0] cmd_resp_cluster_id_o,
    output logic [CORE_ID_WIDTH-1:0]    cmd_resp_core_id_o,
    output logic [LOCAL_ID_WIDTH-1:0]   cmd_resp_local_id_o,
    output logic [CNT_W-1:0]            inflight_o,
    output logic                        idle_o,
    output logic                        err_o
);

    logic [NUM_INFLIGHT-1:0]     busy;
    logic [NUM_INFLIGHT-1:0]     issued;
    logic [CLUSTER_ID_WIDTH-1:0] cluster_mem [NUM_INFLIGHT];
    logic [CORE_ID_WIDTH-1:0]    core_mem    [NUM_INFLIGHT];
    logic [LOCAL_ID_WIDTH-1:0]   local_mem   [NUM_INFLIGHT];

    logic [TAG_W-1:0] free_tag;
    logic             any_free;
    logic             alloc;
    logic             issue_hs;
    logic             done_ok;
    logic             done_bad;

    // Lowest free tag and handshake qualifiers; a done only counts once its tag has left the issue register
    always_comb begin
        free_tag = '0;
        for (int i = NUM_INFLIGHT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_tag = TAG_W'(i);
            end
        end
        any_free    = ~&busy;
        cmd_ready_o = any_free && (!eng_valid_o || eng_ready_i);
        alloc       = cmd_valid_i && cmd_ready_o;
        issue_hs    = eng_valid_o && eng_ready_i;
        done_ok     = eng_done_valid_i && busy[eng_done_tag_i] && issued[eng_done_tag_i];
        done_bad    = eng_done_valid_i && !done_ok;
        idle_o      = (inflight_o == '0) && !eng_valid_o;
    end

    // Per-tag busy/issued bookkeeping; alloc, issue and done always target distinct tags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy   <= '0;
            issued <= '0;
        end else begin
            if (done_ok) begin
                busy[eng_done_tag_i]   <= 1'b0;
                issued[eng_done_tag_i] <= 1'b0;
            end
            if (issue_hs) begin
                issued[eng_tag_o] <= 1'b1;
            end
            if (alloc) begin
                busy[free_tag]   <= 1'b1;
                issued[free_tag] <= 1'b0;
            end
        end
    end

    // Requester IDs captured at allocation; contents only matter while the tag is busy
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            cluster_mem[free_tag] <= cmd_cluster_id_i;
            core_mem[free_tag]    <= cmd_core_id_i;
            local_mem[free_tag]   <= cmd_local_id_i;
        end
    end

    // Issue register toward the engine, reloaded directly on back-to-back accepts
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            eng_valid_o   <= 1'b0;
            eng_tag_o     <= '0;
            eng_payload_o <= '0;
        end else if (alloc) begin
            eng_valid_o   <= 1'b1;
            eng_tag_o     <= free_tag;
            eng_payload_o <= cmd_payload_i;
        end else if (issue_hs) begin
            eng_valid_o <= 1'b0;
        end
    end

    // One-cycle completion broadcast with IDs zeroed when idle
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cmd_resp_valid_o      <= 1'b0;
            cmd_resp_cluster_id_o <= '0;
            cmd_resp_core_id_o    <= '0;
            cmd_resp_local_id_o   <= '0;
        end else begin
            cmd_resp_valid_o      <= done_ok;
            cmd_resp_cluster_id_o <= done_ok ? cluster_mem[eng_done_tag_i] : '0;
            cmd_resp_core_id_o    <= done_ok ? core_mem[eng_done_tag_i]    : '0;
            cmd_resp_local_id_o   <= done_ok ? local_mem[eng_done_tag_i]   : '0;
        end
    end

    // Busy-tag counter and sticky protocol error flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            inflight_o <= '0;
            err_o      <= 1'b0;
        end else begin
            inflight_o <= inflight_o + CNT_W'(alloc) - CNT_W'(done_ok);
            err_o      <= err_o | done_bad;
        end
    end

endmodule

// File: tb/tb_cmd_completer.sv
// tb/tb_cmd_completer.sv - scoreboard bench for cmd_completer
module tb_cmd_completer;
    localparam int N  = 8;
    localparam int CW = 16;
    localparam int KW = 16;
    localparam int LW = 2;
    localparam int PW = 64;
    localparam int TW = 3;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_cl = '0;
    logic [KW-1:0] cmd_co = '0;
    logic [LW-1:0] cmd_lo = '0;
    logic [PW-1:0] cmd_pl = '0;
    logic          eng_valid;
    logic          eng_ready = 1'b0;
    logic [TW-1:0] eng_tag;
    logic [PW-1:0] eng_pl;
    logic          done_valid = 1'b0;
    logic [TW-1:0] done_tag = '0;
    logic          resp_valid;
    logic [CW-1:0] resp_cl;
    logic [KW-1:0] resp_co;
    logic [LW-1:0] resp_lo;
    logic [NW-1:0] inflight;
    logic          idle;
    logic          err;

    cmd_completer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_cluster_id_i(cmd_cl), .cmd_core_id_i(cmd_co),
        .cmd_local_id_i(cmd_lo), .cmd_payload_i(cmd_pl),
        .eng_valid_o(eng_valid), .eng_ready_i(eng_ready),
        .eng_tag_o(eng_tag), .eng_payload_o(eng_pl),
        .eng_done_valid_i(done_valid), .eng_done_tag_i(done_tag),
        .cmd_resp_valid_o(resp_valid), .cmd_resp_cluster_id_o(resp_cl),
        .cmd_resp_core_id_o(resp_co), .cmd_resp_local_id_o(resp_lo),
        .inflight_o(inflight), .idle_o(idle), .err_o(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: set of busy tags, which have reached the engine, and what each belongs to
    typedef struct { logic [TW-1:0] tag; logic [PW-1:0] pl; } iss_t;
    typedef struct { int due; logic [CW-1:0] cl; logic [KW-1:0] co; logic [LW-1:0] lo; } rsp_t;
    iss_t eng_q[$];
    rsp_t rsp_q[$];
    bit            m_busy[N];
    bit            m_iss[N];
    logic [CW-1:0] m_cl[N];
    logic [KW-1:0] m_co[N];
    logic [LW-1:0] m_lo[N];
    bit            m_pend;
    int            m_ptag;
    bit            m_err;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic int m_lowest();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic int pick_done();
        int cand[$];
        for (int i = 0; i < N; i++) if (m_busy[i] && m_iss[i]) cand.push_back(i);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            m_iss[i]  = 0;
        end
        m_pend = 0;
        m_err  = 0;
        eng_q.delete();
        rsp_q.delete();
    endfunction

    // One clock of stimulus; the model predicts ready and queues expected issue/response traffic
    task automatic step(input bit cv, input logic [CW-1:0] cl, input logic [KW-1:0] co,
                        input logic [LW-1:0] lo, input logic [PW-1:0] pl,
                        input bit er, input bit dv, input int dt);
        bit exp_ready, ok;
        int lt;
        @(posedge clk);
        #1;
        cmd_valid = cv; cmd_cl = cl; cmd_co = co; cmd_lo = lo; cmd_pl = pl;
        eng_ready = er; done_valid = dv; done_tag = TW'(dt);
        @(negedge clk);
        chk("inflight", 64'(inflight), 64'(m_count()));
        chk("idle", 64'(idle), 64'(m_count() == 0 && !m_pend));
        chk("err", 64'(err), 64'(m_err));
        exp_ready = (m_count() < N) && (!m_pend || er);
        chk("cmd_ready", 64'(cmd_ready), 64'(exp_ready));
        ok = dv && m_busy[dt] && m_iss[dt];
        lt = m_lowest();
        if (ok) begin
            rsp_q.push_back('{cyc + 1, m_cl[dt], m_co[dt], m_lo[dt]});
            m_busy[dt] = 0;
            m_iss[dt]  = 0;
        end else if (dv) begin
            m_err = 1;
        end
        if (m_pend && er) begin
            m_iss[m_ptag] = 1;
            m_pend = 0;
        end
        if (cv && exp_ready) begin
            eng_q.push_back('{TW'(lt), pl});
            m_busy[lt] = 1; m_iss[lt] = 0;
            m_cl[lt] = cl; m_co[lt] = co; m_lo[lt] = lo;
            m_pend = 1; m_ptag = lt;
        end
    endtask

    task automatic idle_step(input bit er);
        step(0, '0, '0, '0, '0, er, 0, 0);
    endtask

    task automatic cmd_step(input bit er);
        step(1, CW'($urandom), KW'($urandom), LW'($urandom), {$urandom, $urandom}, er, 0, 0);
    endtask

    task automatic drain();
        int t;
        repeat (N + 4) begin
            t = pick_done();
            step(0, '0, '0, '0, '0, 1, t >= 0, t >= 0 ? t : 0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_ni = 0; cmd_valid = 0; eng_ready = 0; done_valid = 0;
        @(negedge clk);
        #1;
        m_clear();
        mon_en = 1;
        @(posedge clk);
        #1;
        rst_ni = 1;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'(1));
        chk("rst_idle", 64'(idle), 64'(1));
        chk("rst_inflight", 64'(inflight), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_eng_valid", 64'(eng_valid), 64'(0));
    endtask

    // Monitor: checks engine issue and completion broadcasts against queued expectations
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (eng_valid === 1'b1) begin
                    if (eng_q.size() == 0) begin
                        chk("eng_unexpected", 64'(eng_valid), 64'(0));
                    end else begin
                        chk("eng_tag", 64'(eng_tag), 64'(eng_q[0].tag));
                        chk("eng_payload", eng_pl, eng_q[0].pl);
                        if (eng_ready) void'(eng_q.pop_front());
                    end
                end
                if (resp_valid === 1'b1) begin
                    if (rsp_q.size() == 0 || rsp_q[0].due != cyc) begin
                        chk("resp_unexpected", 64'(resp_valid), 64'(0));
                    end else begin
                        chk("resp_ids", 64'({resp_cl, resp_co, resp_lo}),
                            64'({rsp_q[0].cl, rsp_q[0].co, rsp_q[0].lo}));
                        void'(rsp_q.pop_front());
                    end
                end else begin
                    chk("resp_ids_zero", 64'({resp_cl, resp_co, resp_lo}), 64'(0));
                    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                        chk("resp_missing", 64'(resp_valid), 64'(1));
                        void'(rsp_q.pop_front());
                    end
                end
            end
        end
    end

    // Directed scenarios followed by random traffic
    initial begin
        int t;
        m_clear();
        do_reset();

        // single command, done two cycles after issue
        step(1, 16'd3, 16'd5, 2'd1, 64'hAB, 1, 0, 0);
        idle_step(1);
        idle_step(1);
        step(0, '0, '0, '0, '0, 1, 1, 0);
        idle_step(1);
        idle_step(1);

        // fill all tags, then free tag 2 for the ninth command
        repeat (9) cmd_step(1);
        step(1, 16'h99, 16'h77, 2'd2, 64'h9, 1, 1, 2);
        cmd_step(1);
        drain();

        // engine backpressure
        cmd_step(1);
        repeat (4) cmd_step(0);
        cmd_step(1);
        idle_step(1);
        drain();

        // out-of-order completion
        repeat (3) cmd_step(1);
        idle_step(1);
        step(0, '0, '0, '0, '0, 1, 1, 2);
        step(0, '0, '0, '0, '0, 1, 1, 0);
        step(0, '0, '0, '0, '0, 1, 1, 1);
        idle_step(1);
        idle_step(1);

        // protocol errors: done on idle tag, done on tag still in the issue register
        step(0, '0, '0, '0, '0, 1, 1, 5);
        cmd_step(0);
        step(0, '0, '0, '0, '0, 0, 1, 0);
        idle_step(1);
        drain();

        // reset with commands in flight
        repeat (3) cmd_step(1);
        do_reset();
        cmd_step(1);
        idle_step(1);
        drain();
        do_reset();

        // random traffic
        repeat (600) begin
            t = ($urandom_range(99) < 85) ? pick_done() : int'($urandom_range(N - 1));
            step($urandom_range(99) < 60, CW'($urandom), KW'($urandom), LW'($urandom),
                 {$urandom, $urandom}, $urandom_range(99) < 70,
                 (t >= 0) && ($urandom_range(99) < 35), t >= 0 ? t : 0);
            if ($urandom_range(299) == 0) do_reset();
        end
        idle_step(1);
        drain();
        idle_step(1);
        idle_step(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_completer.md
CMD_COMPLETER -- requirements
Module: cmd_completer

Interface
REQ-001 SHALL have parameter CLUSTER_ID_WIDTH, default 16, width of command-ID cluster field.
REQ-002 SHALL have parameter CORE_ID_WIDTH, default 16, width of command-ID core field.
REQ-003 SHALL have parameter LOCAL_ID_WIDTH, default 2, width of per-HPU command slot ID.
REQ-004 SHALL have parameter PAYLOAD_WIDTH, default 64, opaque command payload width.
REQ-005 SHALL have parameter NUM_INFLIGHT, default 8 (power of 2, >=2); TAG_W = clog2(NUM_INFLIGHT).
REQ-006 SHALL have port clk_i, input, 1 bit, the single clock; all state on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1 bit, reset, synchronous and active-low.
REQ-008 SHALL have ports cmd_valid_i in 1, cmd_ready_o out 1: command input handshake from HPU drivers.
REQ-009 SHALL have ports cmd_cluster_id_i in CLUSTER_ID_WIDTH, cmd_core_id_i in CORE_ID_WIDTH, cmd_local_id_i in LOCAL_ID_WIDTH, cmd_payload_i in PAYLOAD_WIDTH.
REQ-010 SHALL have ports eng_valid_o out 1, eng_ready_i in 1, eng_tag_o out TAG_W, eng_payload_o out PAYLOAD_WIDTH: issue to execution engine.
REQ-011 SHALL have ports eng_done_valid_i in 1, eng_done_tag_i in TAG_W: engine completion, no backpressure.
REQ-012 SHALL have ports cmd_resp_valid_o out 1, cmd_resp_cluster_id_o, cmd_resp_core_id_o, cmd_resp_local_id_o (widths as REQ-009): broadcast completion notification, no ready.
REQ-013 SHALL have ports inflight_o out clog2(NUM_INFLIGHT+1) (busy-tag count), idle_o out 1, err_o out 1 (sticky protocol error).

Function
REQ-014 SHALL keep per tag: busy bit, issued bit, stored cluster/core/local ID.
REQ-015 SHALL drive cmd_ready_o = (any tag not busy) AND (!eng_valid_o OR eng_ready_i), using registered busy bits only.
REQ-016 SHALL, on cmd_valid_i && cmd_ready_o, allocate the lowest-index non-busy tag, set busy, clear issued, store IDs, load issue register with tag/payload; eng_valid_o high next cycle.
REQ-017 SHALL hold eng_valid_o/eng_tag_o/eng_payload_o stable until eng_ready_i; on handshake set issued[tag] and drop eng_valid_o unless a new command is accepted the same cycle (back-to-back, 1 command/cycle).
REQ-018 SHALL, on eng_done_valid_i with tag busy AND issued, clear busy/issued at that edge and assert cmd_resp_valid_o for exactly one cycle the next cycle with that tag's stored IDs.
REQ-019 SHALL ignore eng_done_valid_i on a tag not busy or not yet issued (including done in the same cycle as its issue handshake) and set err_o, held until reset.
REQ-020 SHALL permit a freed tag to be reallocated no earlier than the cycle after its done; alloc and done on different tags in the same cycle both take effect.
REQ-021 SHALL drive cmd_resp ID outputs to zero whenever cmd_resp_valid_o is low.
REQ-022 SHALL update inflight_o each edge as popcount(busy) (+1 alloc, -1 valid done, net 0 when both); idle_o = (inflight_o == 0) && !eng_valid_o.
REQ-023 SHALL deassert cmd_ready_o when all NUM_INFLIGHT tags busy; accepted commands never dropped.

Reset
REQ-024 SHALL, while rst_ni low at a clock edge, clear all busy/issued bits, eng_valid_o=0, cmd_resp_valid_o=0, err_o=0, inflight_o=0, eng_tag_o/eng_payload_o/response IDs=0; idle_o=1 from next cycle.
REQ-025 SHALL, on reset mid-operation, discard all in-flight commands without emitting responses; cmd_ready_o=1 the first cycle after rst_ni returns high.

Verification
REQ-026 Single command: IDs (3,5,1), payload 0xAB, eng_ready_i=1, done tag 0 two cycles after issue -> eng_tag_o=0, one response (3,5,1) the cycle after done, inflight 1->0, err_o=0.
REQ-027 Fill: NUM_INFLIGHT=8, eng_ready_i=1, no dones, 9 commands offered -> tags 0..7 issued in order, cmd_ready_o=0 after 8th, inflight_o=8; done tag 2 -> 9th command gets tag 2 one cycle later.
REQ-028 Backpressure: eng_ready_i=0 for 4 cycles with command pending -> eng outputs stable, cmd_ready_o=0, second command accepted the cycle eng_ready_i rises.
REQ-029 Out-of-order completion: tags 0,1,2 issued, dones 2,0,1 on consecutive cycles -> three consecutive single-cycle responses with matching IDs, inflight 3->0.
REQ-030 Errors: done tag 5 when idle, and done on tag held in un-issued register -> no response, busy unchanged, err_o=1 sticky until reset.
REQ-031 Reset mid-operation: 3 in flight, rst_ni low 1 cycle -> no responses, inflight_o=0, idle_o=1, next command gets tag 0.
